t_pulse_gen: RTL and testbench

Synchronous toggle-command generator that sits directly upstream of the team's T storage element. It accepts a command (pulse count and inter-pulse gap) over a valid/ready handshake and drives the downstream `en`/`t` inputs with exactly that many one-cycle toggle pulses. It also keeps a model of the downstream `q` state so that the verification engineer and system logic can check the latch against an expected value.

---
 rtl/t_pulse_gen.sv | 122 ++++++++++++
 tb/tb_t_pulse_gen.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/t_pulse_gen.sv
// Toggle-command generator driving the en/t inputs of a downstream T stage.
// Issues N one-cycle toggle pulses separated by a programmable gap and tracks the expected q.
module t_pulse_gen #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [GAP_W-1:0] cmd_gap,
  input  logic             abort,
  output logic             en,
  output logic             t,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] pulses_sent,
  output logic             q_expect
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [GAP_W-1:0] gap_lat;
  logic [GAP_W-1:0] gap_cnt;

  // Only the handshake ready is combinational; it must drop while rst is held.
  assign cmd_ready = (state == IDLE) && !rst;

  // Single-process FSM; every output is computed for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      remaining   <= '0;
      gap_lat     <= '0;
      gap_cnt     <= '0;
      en          <= 1'b0;
      t           <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      pulses_sent <= '0;
      q_expect    <= 1'b0;
    end else begin
      en   <= 1'b0;
      t    <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            remaining   <= cmd_count;
            gap_lat     <= cmd_gap;
            pulses_sent <= '0;
            aborted     <= 1'b0;
            if (cmd_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= PULSE;
              en    <= 1'b1;
              t     <= 1'b1;
              busy  <= 1'b1;
            end
          end
        end
        PULSE: begin
          // The pulse in flight always counts, even when abort arrives with it.
          remaining   <= remaining - CNT_W'(1);
          pulses_sent <= pulses_sent + CNT_W'(1);
          q_expect    <= ~q_expect;
          if (remaining == CNT_W'(1)) begin
            state   <= DONE;
            done    <= 1'b1;
            aborted <= 1'b0;
          end else if (abort) begin
            state   <= DONE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (gap_lat == '0) begin
            en   <= 1'b1;
            t    <= 1'b1;
            busy <= 1'b1;
          end else begin
            state   <= GAP;
            gap_cnt <= gap_lat;
            busy    <= 1'b1;
          end
        end
        GAP: begin
          if (abort) begin
            state   <= DONE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (gap_cnt == GAP_W'(1)) begin
            state <= PULSE;
            en    <= 1'b1;
            t     <= 1'b1;
            busy  <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
            busy    <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          aborted <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t_pulse_gen.sv
// Directed, table-driven bench for t_pulse_gen plus hand-written multi-cycle sequences.
module tb_t_pulse_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_count;
  logic [3:0] cmd_gap;
  logic       abort;
  logic       en, t, busy, done, aborted, q_expect;
  logic [7:0] pulses_sent;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  t_pulse_gen #(.CNT_W(8), .GAP_W(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_count(cmd_count), .cmd_gap(cmd_gap), .abort(abort),
    .en(en), .t(t), .busy(busy), .done(done), .aborted(aborted),
    .pulses_sent(pulses_sent), .q_expect(q_expect)
  );

  // Inputs presented in a cycle and the outputs expected in that same cycle.
  // exp = {en, t, busy, done, aborted, cmd_ready, pulses_sent[7:0], q_expect}
  typedef struct {
    logic        r;
    logic        v;
    logic [7:0]  cnt;
    logic [3:0]  gap;
    logic        ab;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic v, input int cnt, input int gap,
                              input logic ab, input logic [5:0] flags, input int ps,
                              input logic q);
    vec_t x;
    x.r   = r;
    x.v   = v;
    x.cnt = 8'(cnt);
    x.gap = 4'(gap);
    x.ab  = ab;
    x.exp = {flags, 8'(ps), q};
    return x;
  endfunction

  function automatic logic [14:0] outs();
    return {en, t, busy, done, aborted, cmd_ready, pulses_sent, q_expect};
  endfunction

  task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic drive(input logic r, input logic v, input int cnt, input int gap, input logic ab);
    rst       = r;
    cmd_valid = v;
    cmd_count = 8'(cnt);
    cmd_gap   = 4'(gap);
    abort     = ab;
  endtask

  int t_exp[7];
  int r_exp[7];
  int accepts;
  int waited;

  initial begin
    drive(1'b1, 1'b0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);

    //            r v cnt gap ab   en t busy done abo rdy   ps  q
    vecs.push_back(mk(1, 0, 0, 0, 0, 6'b000000, 0, 0)); // reset state, ready low
    vecs.push_back(mk(0, 1, 3, 0, 0, 6'b000001, 0, 0)); // accept 3 pulses, gap 0
    vecs.push_back(mk(0, 0, 0, 0, 0, 6'b111000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 6'b111000, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 6'b111000, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 6'b000100, 3, 1)); // done at k+4
    vecs.push_back(mk(0, 1, 2, 2, 0, 6'b000001, 3, 1)); // accept 2 pulses, gap 2
    vecs.push_back(mk(0, 0, 0, 0, 0, 6'b111000, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 6'b001000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 6'b001000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 6'b111000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 6'b000100, 2, 1)); // done at k+5, q back
    vecs.push_back(mk(0, 1, 0, 0, 0, 6'b000001, 2, 1)); // zero-count command
    vecs.push_back(mk(0, 0, 0, 0, 0, 6'b000100, 0, 1)); // done at k+1
    vecs.push_back(mk(0, 1, 5, 1, 0, 6'b000001, 0, 1)); // 5 pulses, gap 1
    vecs.push_back(mk(0, 0, 0, 0, 0, 6'b111000, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 6'b001000, 1, 0)); // abort in first GAP
    vecs.push_back(mk(0, 0, 0, 0, 0, 6'b000110, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 6'b000001, 1, 0)); // single pulse
    vecs.push_back(mk(0, 0, 0, 0, 1, 6'b111000, 0, 0)); // abort on final pulse
    vecs.push_back(mk(0, 0, 0, 0, 0, 6'b000100, 1, 1)); // completion wins
    vecs.push_back(mk(0, 1, 3, 3, 0, 6'b000001, 1, 1)); // 3 pulses, gap 3
    vecs.push_back(mk(0, 0, 0, 0, 1, 6'b111000, 0, 1)); // abort during a PULSE
    vecs.push_back(mk(0, 0, 0, 0, 0, 6'b000110, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 6'b000001, 1, 0)); // abort ignored in IDLE
    vecs.push_back(mk(0, 0, 0, 0, 0, 6'b000001, 1, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].r, vecs[i].v, 32'(vecs[i].cnt), 32'(vecs[i].gap), vecs[i].ab);
      #1;
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // cmd_valid held high across a whole train: second accept only from IDLE.
    t_exp = '{0, 1, 0, 1, 0, 0, 1};
    r_exp = '{1, 0, 0, 0, 0, 1, 0};
    accepts = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 2, 1, 1'b0);
      #1;
      if (cmd_ready && cmd_valid) accepts++;
      check($sformatf("held_t_c%0d", c), 15'(t), 15'(t_exp[c]));
      check($sformatf("held_rdy_c%0d", c), 15'(cmd_ready), 15'(r_exp[c]));
    end
    check("held_accepts", 15'(accepts), 15'(2));
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 0, 1'b0);
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("held_return_idle", 15'(cmd_ready), 15'(1));
    check("held_ps", 15'(pulses_sent), 15'(2));

    // Reset during the 3rd pulse of an 8-pulse train.
    @(negedge clk);
    drive(1'b0, 1'b1, 8, 0, 1'b0);
    repeat (2) @(negedge clk);
    drive(1'b0, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    #1;
    check("rst_third_pulse_t", 15'(t), 15'(1));
    check("rst_third_pulse_ps", 15'(pulses_sent), 15'(2));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_after", outs(), {6'b000001, 8'd0, 1'b0});
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("rst_no_stray_c%0d", c), {13'd0, en, t}, 15'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
